// File: rtl/active_devices_monitor_n.sv
// Active-device monitor: per-channel connect/disconnect tracking, live count, hysteresis alarm.
// Optional peak-count register enabled by defining PEAK_HOLD_EN.
module active_devices_monitor_n #(
    parameter int unsigned N_DEV    = 8,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned ALARM_HI = 6,
    parameter int unsigned ALARM_LO = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_DEV-1:0] dev_on,
    input  logic [N_DEV-1:0] dev_off,
`ifdef PEAK_HOLD_EN
    input  logic             clr_peak,
    output logic [CNT_W-1:0] peak,
`endif
    output logic [N_DEV-1:0] active_map,
    output logic [CNT_W-1:0] count,
    output logic             alarm,
    output logic             evt_err
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] ALERT = 1'b1;

    localparam logic [CNT_W-1:0] HI_TH = CNT_W'(ALARM_HI);
    localparam logic [CNT_W-1:0] LO_TH = CNT_W'(ALARM_LO);

    logic [0:0]       state, state_nxt;
    logic [N_DEV-1:0] map_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;

    // Per-channel event evaluation; simultaneous on+off is a no-op
    always_comb begin
        map_nxt = active_map;
        err_nxt = 1'b0;
        if (enable) begin
            for (int i = 0; i < int'(N_DEV); i++) begin
                case ({dev_on[i], dev_off[i]})
                    2'b10: begin
                        if (active_map[i]) err_nxt = 1'b1;
                        else               map_nxt[i] = 1'b1;
                    end
                    2'b01: begin
                        if (active_map[i]) map_nxt[i] = 1'b0;
                        else               err_nxt = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Count is recomputed from the next map so it can never drift from it
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(map_nxt[i]);
        end
    end

    // Alarm next-state with hysteresis between LO_TH and HI_TH
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt_nxt >= HI_TH) state_nxt = ALERT;
            ALERT:   if (cnt_nxt <= LO_TH) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            active_map <= '0;
            count      <= '0;
            evt_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            active_map <= map_nxt;
            count      <= cnt_nxt;
            evt_err    <= err_nxt;
        end
    end

    assign alarm = (state == ALERT);

`ifdef PEAK_HOLD_EN
    // Peak tracks the post-edge count; clear reloads it and ignores enable
    always_ff @(posedge clk) begin
        if (rst) begin
            peak <= '0;
        end else if (clr_peak) begin
            peak <= cnt_nxt;
        end else if (cnt_nxt > peak) begin
            peak <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_active_devices_monitor_n.sv
// Directed vector bench for active_devices_monitor_n; peak checks only when PEAK_HOLD_EN is defined.
module tb_active_devices_monitor_n;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [7:0] on;
        logic [7:0] off;
        logic       clr;
        logic [7:0] emap;
        logic [3:0] ecnt;
        logic       eal;
        logic       eerr;
        logic [3:0] epk;
    } vec_t;

    localparam int NV = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] dev_on;
    logic [7:0] dev_off;
    logic [7:0] active_map;
    logic [3:0] count;
    logic       alarm;
    logic       evt_err;
`ifdef PEAK_HOLD_EN
    logic       clr_peak;
    logic [3:0] peak;
`endif

    int n_pass  = 0;
    int n_total = 0;
    vec_t vt[NV];

    active_devices_monitor_n #(
        .N_DEV(8), .CNT_W(4), .ALARM_HI(6), .ALARM_LO(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .dev_on     (dev_on),
        .dev_off    (dev_off),
`ifdef PEAK_HOLD_EN
        .clr_peak   (clr_peak),
        .peak       (peak),
`endif
        .active_map (active_map),
        .count      (count),
        .alarm      (alarm),
        .evt_err    (evt_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic [7:0] on, logic [7:0] off, logic c,
                                logic [7:0] em, logic [3:0] ec, logic ea, logic ee, logic [3:0] ep);
        vec_t v;
        v.rst = r; v.en = e; v.on = on; v.off = off; v.clr = c;
        v.emap = em; v.ecnt = ec; v.eal = ea; v.eerr = ee; v.epk = ep;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst     = v.rst;
        enable  = v.en;
        dev_on  = v.on;
        dev_off = v.off;
`ifdef PEAK_HOLD_EN
        clr_peak = v.clr;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        chk("active_map", idx, 32'(active_map), 32'(v.emap));
        chk("count",      idx, 32'(count),      32'(v.ecnt));
        chk("alarm",      idx, 32'(alarm),      32'(v.eal));
        chk("evt_err",    idx, 32'(evt_err),    32'(v.eerr));
`ifdef PEAK_HOLD_EN
        chk("peak",       idx, 32'(peak),       32'(v.epk));
`endif
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; dev_on = '0; dev_off = '0;
`ifdef PEAK_HOLD_EN
        clr_peak = 1'b0;
`endif
        //          rst en  on     off    clr  map    cnt  al   err  pk
        vt[0]  = mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 4'd0, 0, 0, 4'd0);
        vt[1]  = mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 4'd0, 0, 0, 4'd0);
        vt[2]  = mk(0, 1, 8'h07, 8'h00, 0, 8'h07, 4'd3, 0, 0, 4'd3);
        vt[3]  = mk(0, 1, 8'h18, 8'h00, 0, 8'h1F, 4'd5, 0, 0, 4'd5);
        vt[4]  = mk(0, 1, 8'h20, 8'h00, 0, 8'h3F, 4'd6, 1, 0, 4'd6);
        vt[5]  = mk(0, 1, 8'h00, 8'h30, 0, 8'h0F, 4'd4, 1, 0, 4'd6);
        vt[6]  = mk(0, 1, 8'h00, 8'h0C, 0, 8'h03, 4'd2, 0, 0, 4'd6);
        vt[7]  = mk(0, 1, 8'h00, 8'h02, 0, 8'h01, 4'd1, 0, 0, 4'd6);
        vt[8]  = mk(0, 1, 8'h03, 8'h04, 0, 8'h03, 4'd2, 0, 1, 4'd6);
        vt[9]  = mk(0, 1, 8'h00, 8'h00, 0, 8'h03, 4'd2, 0, 0, 4'd6);
        vt[10] = mk(0, 1, 8'hFF, 8'hFF, 0, 8'h03, 4'd2, 0, 0, 4'd6);
        vt[11] = mk(0, 0, 8'hFF, 8'h00, 0, 8'h03, 4'd2, 0, 0, 4'd6);
        vt[12] = mk(0, 0, 8'h00, 8'h03, 0, 8'h03, 4'd2, 0, 0, 4'd6);
        vt[13] = mk(0, 1, 8'h00, 8'h03, 0, 8'h00, 4'd0, 0, 0, 4'd6);
        vt[14] = mk(0, 1, 8'hFF, 8'hFF, 0, 8'h00, 4'd0, 0, 0, 4'd6);
        vt[15] = mk(0, 1, 8'hFF, 8'h00, 0, 8'hFF, 4'd8, 1, 0, 4'd8);
        vt[16] = mk(0, 1, 8'h01, 8'h00, 0, 8'hFF, 4'd8, 1, 1, 4'd8);
        vt[17] = mk(1, 1, 8'h00, 8'hFF, 0, 8'h00, 4'd0, 0, 0, 4'd0);
        vt[18] = mk(0, 1, 8'h1F, 8'h00, 0, 8'h1F, 4'd5, 0, 0, 4'd5);
        vt[19] = mk(0, 1, 8'h00, 8'h1E, 0, 8'h01, 4'd1, 0, 0, 4'd5);
        vt[20] = mk(0, 0, 8'h00, 8'h00, 1, 8'h01, 4'd1, 0, 0, 4'd1);
        vt[21] = mk(0, 1, 8'hFE, 8'h00, 0, 8'hFF, 4'd8, 1, 0, 4'd8);
        vt[22] = mk(0, 1, 8'h00, 8'hFF, 0, 8'h00, 4'd0, 0, 0, 4'd8);
        vt[23] = mk(0, 1, 8'h07, 8'h00, 1, 8'h07, 4'd3, 0, 0, 4'd3);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            check_vec(vt[i], i);
        end

        // Error pulse must last one cycle even when enable drops right after
        drive(mk(0, 1, 8'h02, 8'h08, 0, 8'h07, 4'd3, 0, 1, 4'd3));
        chk("err_pulse_hi", 100, 32'(evt_err), 32'd1);
        drive(mk(0, 0, 8'h02, 8'h08, 0, 8'h07, 4'd3, 0, 0, 4'd3));
        chk("err_pulse_lo", 101, 32'(evt_err), 32'd0);
        chk("err_hold_map", 101, 32'(active_map), 32'h07);

        // Reset mid-burst drops the pending events and clears the alarm
        drive(mk(0, 1, 8'hF8, 8'h00, 0, 8'hFF, 4'd8, 1, 0, 4'd8));
        chk("burst_alarm", 102, 32'(alarm), 32'd1);
        drive(mk(1, 1, 8'h00, 8'hFF, 0, 8'h00, 4'd0, 0, 0, 4'd0));
        chk("rst_map",   103, 32'(active_map), 32'h00);
        chk("rst_count", 103, 32'(count),      32'd0);
        chk("rst_alarm", 103, 32'(alarm),      32'd0);
        chk("rst_err",   103, 32'(evt_err),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
